// File: rtl/uartrx_ctrl_if.sv
// Handshake bundle between the UART receiver, the receive controller and the CPU-side consumer.
// slave = controller side, master = receiver/consumer side.
interface uartrx_ctrl_if #(
  parameter int Depth = 16
);
  localparam int CountWidth = $clog2(Depth + 1);

  logic [7:0]            urx_data;
  logic                  urx_data_ready;
  logic                  urx_go;
  logic [7:0]            rd_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [CountWidth-1:0] count;
  logic                  overrun;
  logic                  clr_overrun;
  logic                  timeout;

  modport slave (
    input  urx_data, urx_data_ready, rd_ready, clr_overrun,
    output urx_go, rd_data, rd_valid, count, overrun, timeout
  );

  modport master (
    output urx_data, urx_data_ready, rd_ready, clr_overrun,
    input  urx_go, rd_data, rd_valid, count, overrun, timeout
  );
endinterface

// File: rtl/uartrx_ctrl.sv
// UART receive controller: go/data_ready handshake FSM feeding a FWFT byte FIFO with sticky overrun.
// Optional idle timeout is enabled by defining UARTRX_CTRL_TIMEOUT_EN.
module uartrx_ctrl #(
  parameter int Depth            = 16,
  parameter int ClockFrequencyHz = 66_000_000,
  parameter int BaudRate         = 9600,
  parameter int TimeoutBitTimes  = 40
) (
  input  logic         clk,
  input  logic         rst_n,
  uartrx_ctrl_if.slave bus
);
  localparam int PtrW = $clog2(Depth);
  localparam int CntW = $clog2(Depth + 1);
  localparam logic [CntW-1:0] DepthC = CntW'(Depth);

  typedef enum logic [0:0] {
    ST_RELEASE = 1'b0,
    ST_ARM     = 1'b1
  } state_e;

  state_e          state_r;
  logic            go_r;
  logic [7:0]      mem_r [Depth];
  logic [PtrW-1:0] wr_ptr_r;
  logic [PtrW-1:0] rd_ptr_r;
  logic [CntW-1:0] count_r;
  logic            valid_r;
  logic [7:0]      data_r;
  logic            overrun_r;

  logic            push_s;
  logic            pop_s;
  logic            accept_s;
  logic            drop_s;
  logic [PtrW-1:0] rd_ptr_nxt_s;
  logic [CntW-1:0] count_nxt_s;

  // Handshake FSM; a data_ready still high after reset is acknowledged by staying in Release.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_RELEASE;
      go_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_RELEASE: begin
          if (!bus.urx_data_ready) begin
            state_r <= ST_ARM;
            go_r    <= 1'b1;
          end
        end
        ST_ARM: begin
          if (bus.urx_data_ready) begin
            state_r <= ST_RELEASE;
            go_r    <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_RELEASE;
          go_r    <= 1'b0;
        end
      endcase
    end
  end

  // FIFO control: a pop in the same cycle frees room for a push even when full.
  always_comb begin
    push_s       = (state_r == ST_ARM) && bus.urx_data_ready;
    pop_s        = valid_r && bus.rd_ready;
    accept_s     = push_s && ((count_r != DepthC) || pop_s);
    drop_s       = push_s && !accept_s;
    rd_ptr_nxt_s = rd_ptr_r;
    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PtrW'(1);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    case ({accept_s, pop_s})
      2'b10:   count_nxt_s = count_r + CntW'(1);
      2'b01:   count_nxt_s = count_r - CntW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Byte storage.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_r[wr_ptr_r] <= bus.urx_data;
    end
  end

  // Pointers, occupancy and registered head byte; a push landing on the new head is bypassed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      valid_r  <= 1'b0;
      data_r   <= 8'h00;
    end else begin
      if (accept_s) begin
        wr_ptr_r <= wr_ptr_r + PtrW'(1);
      end
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
      valid_r  <= (count_nxt_s != CntW'(0));
      if (accept_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
        data_r <= bus.urx_data;
      end else begin
        data_r <= mem_r[rd_ptr_nxt_s];
      end
    end
  end

  // Sticky overrun; a new drop beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overrun_r <= 1'b0;
    end else if (drop_s) begin
      overrun_r <= 1'b1;
    end else if (bus.clr_overrun) begin
      overrun_r <= 1'b0;
    end
  end

  assign bus.urx_go   = go_r;
  assign bus.rd_data  = data_r;
  assign bus.rd_valid = valid_r;
  assign bus.count    = count_r;
  assign bus.overrun  = overrun_r;

`ifdef UARTRX_CTRL_TIMEOUT_EN
  localparam longint unsigned TmoLimit =
    longint'(TimeoutBitTimes) * (longint'(ClockFrequencyHz) / longint'(BaudRate));
  localparam int TmoW =
    $clog2(longint'(TimeoutBitTimes) * longint'(ClockFrequencyHz) / longint'(BaudRate) + 64'd1);
  localparam logic [TmoW-1:0] TmoLimitC = TmoW'(TmoLimit);

  logic [TmoW-1:0] idle_r;
  logic [TmoW-1:0] idle_nxt_s;
  logic            idle_clr_s;
  logic            tmo_r;

  // Saturating idle counter, held at zero while empty or on any traffic.
  always_comb begin
    idle_clr_s = push_s || pop_s || !valid_r;
    if (idle_clr_s) begin
      idle_nxt_s = '0;
    end else if (idle_r == {TmoW{1'b1}}) begin
      idle_nxt_s = idle_r;
    end else begin
      idle_nxt_s = idle_r + TmoW'(1);
    end
  end

  // Idle count and registered timeout flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idle_r <= '0;
      tmo_r  <= 1'b0;
    end else begin
      idle_r <= idle_nxt_s;
      tmo_r  <= !idle_clr_s && (idle_nxt_s >= TmoLimitC);
    end
  end

  assign bus.timeout = tmo_r;
`else
  assign bus.timeout = 1'b0;
`endif
endmodule

// File: tb/tb_uartrx_ctrl.sv
// Directed bench for uartrx_ctrl: per-cycle vector table plus burst, overrun, full push+pop,
// timeout and reset-mid-handshake sequences.
module tb_uartrx_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  uartrx_ctrl_if #(.Depth(16)) bus ();

  uartrx_ctrl #(
    .Depth(16), .ClockFrequencyHz(8), .BaudRate(1), .TimeoutBitTimes(40)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  typedef struct packed {
    logic       rdy;
    logic [7:0] data;
    logic       rr;
    logic       clr;
    logic       chk_go;
    logic       go;
    logic       valid;
    logic [4:0] cnt;
    logic       ovr;
    logic       chk_data;
    logic [7:0] rdata;
  } vec_t;

  vec_t tbl [18];

  function automatic vec_t mk(input logic rdy, input logic [7:0] data, input logic rr,
                              input logic clr, input logic cg, input logic go, input logic v,
                              input logic [4:0] c, input logic o, input logic cd,
                              input logic [7:0] rd);
    vec_t t;
    t = '{rdy, data, rr, clr, cg, go, v, c, o, cd, rd};
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_go();
    int n;
    n = 0;
    while (bus.urx_go !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    chk("wait_go", {31'd0, bus.urx_go}, 32'd1);
  endtask

  // Full handshake: ready held for two edges, then dropped; pop/clear only at the push edge.
  task automatic send_byte(input logic [7:0] b, input logic pop_at, input logic clr_at);
    wait_go();
    bus.urx_data       = b;
    bus.urx_data_ready = 1'b1;
    bus.rd_ready       = pop_at;
    bus.clr_overrun    = clr_at;
    cyc();
    bus.rd_ready    = 1'b0;
    bus.clr_overrun = 1'b0;
    cyc();
    bus.urx_data_ready = 1'b0;
    cyc();
  endtask

  task automatic pop_check(input logic [7:0] exp_b, input logic [4:0] exp_c);
    chk("pop_valid", {31'd0, bus.rd_valid}, 32'd1);
    chk("pop_data", {24'd0, bus.rd_data}, {24'd0, exp_b});
    chk("pop_count", {27'd0, bus.count}, {27'd0, exp_c});
    bus.rd_ready = 1'b1;
    cyc();
    bus.rd_ready = 1'b0;
  endtask

  initial begin
    int k;
    vec_t t;
    tbl[0]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 8'h00);
    tbl[1]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 8'h00);
    tbl[2]  = mk(1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd1, 1'b0, 1'b1, 8'h5A);
    tbl[3]  = mk(1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd1, 1'b0, 1'b1, 8'h5A);
    tbl[4]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd1, 1'b0, 1'b1, 8'h5A);
    tbl[5]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 8'h00);
    tbl[6]  = mk(1'b1, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd1, 1'b0, 1'b1, 8'hC3);
    tbl[7]  = mk(1'b1, 8'hC3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 8'h00);
    tbl[8]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 8'h00);
    tbl[9]  = mk(1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd1, 1'b0, 1'b1, 8'h11);
    tbl[10] = mk(1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd1, 1'b0, 1'b1, 8'h11);
    tbl[11] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd1, 1'b0, 1'b1, 8'h11);
    tbl[12] = mk(1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd2, 1'b0, 1'b1, 8'h11);
    tbl[13] = mk(1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd1, 1'b0, 1'b1, 8'h22);
    tbl[14] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd1, 1'b0, 1'b1, 8'h22);
    tbl[15] = mk(1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd1, 1'b0, 1'b1, 8'h33);
    tbl[16] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 8'h00);
    tbl[17] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 8'h00);

    bus.urx_data       = 8'h00;
    bus.urx_data_ready = 1'b0;
    bus.rd_ready       = 1'b0;
    bus.clr_overrun    = 1'b0;
    repeat (3) cyc();
    chk("rst_go", {31'd0, bus.urx_go}, 32'd0);
    chk("rst_valid", {31'd0, bus.rd_valid}, 32'd0);
    chk("rst_count", {27'd0, bus.count}, 32'd0);
    chk("rst_overrun", {31'd0, bus.overrun}, 32'd0);
    chk("rst_timeout", {31'd0, bus.timeout}, 32'd0);
    rst_n = 1'b1;

    // Per-cycle vectors: inputs set at negedge, outputs compared one edge later.
    for (int i = 0; i < 18; i++) begin
      t = tbl[i];
      bus.urx_data_ready = t.rdy;
      bus.urx_data       = t.data;
      bus.rd_ready       = t.rr;
      bus.clr_overrun    = t.clr;
      cyc();
      if (t.chk_go) chk($sformatf("v%0d_go", i), {31'd0, bus.urx_go}, {31'd0, t.go});
      chk($sformatf("v%0d_valid", i), {31'd0, bus.rd_valid}, {31'd0, t.valid});
      chk($sformatf("v%0d_count", i), {27'd0, bus.count}, {27'd0, t.cnt});
      chk($sformatf("v%0d_overrun", i), {31'd0, bus.overrun}, {31'd0, t.ovr});
      if (t.chk_data) chk($sformatf("v%0d_data", i), {24'd0, bus.rd_data}, {24'd0, t.rdata});
    end
    bus.urx_data_ready = 1'b0;
    bus.rd_ready       = 1'b0;
    bus.clr_overrun    = 1'b0;

    // Burst fill and ordered drain.
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0, 1'b0);
    chk("burst_count", {27'd0, bus.count}, 32'd16);
    chk("burst_overrun", {31'd0, bus.overrun}, 32'd0);
    for (int i = 0; i < 16; i++) pop_check(8'(i), 5'(16 - i));
    chk("burst_valid_end", {31'd0, bus.rd_valid}, 32'd0);
    chk("burst_count_end", {27'd0, bus.count}, 32'd0);
    chk("burst_ovr_end", {31'd0, bus.overrun}, 32'd0);

    // Overrun when full, set-beats-clear, then clear alone.
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0, 1'b0);
    send_byte(8'hEE, 1'b0, 1'b0);
    chk("ovr_count", {27'd0, bus.count}, 32'd16);
    chk("ovr_flag", {31'd0, bus.overrun}, 32'd1);
    chk("ovr_head", {24'd0, bus.rd_data}, 32'h00);
    send_byte(8'hEF, 1'b0, 1'b1);
    chk("ovr_set_wins", {31'd0, bus.overrun}, 32'd1);
    bus.clr_overrun = 1'b1;
    cyc();
    bus.clr_overrun = 1'b0;
    chk("ovr_cleared", {31'd0, bus.overrun}, 32'd0);

    // Push coinciding with a pop at full.
    send_byte(8'h77, 1'b1, 1'b0);
    chk("fpp_count", {27'd0, bus.count}, 32'd16);
    chk("fpp_overrun", {31'd0, bus.overrun}, 32'd0);
    for (int i = 1; i < 16; i++) pop_check(8'(i), 5'(17 - i));
    pop_check(8'h77, 5'd1);
    chk("fpp_empty", {31'd0, bus.rd_valid}, 32'd0);

    // Idle timeout after one byte.
    wait_go();
    bus.urx_data       = 8'h42;
    bus.urx_data_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.urx_data_ready = 1'b0;
    k = 0;
    while (bus.timeout !== 1'b1 && k < 400) begin
      cyc();
      k++;
    end
`ifdef UARTRX_CTRL_TIMEOUT_EN
    chk("tmo_cycles", {31'd0, (k >= 319 && k <= 321)}, 32'd1);
    bus.rd_ready = 1'b1;
    cyc();
    bus.rd_ready = 1'b0;
    chk("tmo_pop_clear", {31'd0, bus.timeout}, 32'd0);
`else
    chk("tmo_disabled", {31'd0, bus.timeout}, 32'd0);
    bus.rd_ready = 1'b1;
    cyc();
    bus.rd_ready = 1'b0;
`endif
    chk("tmo_count", {27'd0, bus.count}, 32'd0);

    // Reset while the receiver still holds data_ready.
    wait_go();
    bus.urx_data       = 8'h99;
    bus.urx_data_ready = 1'b1;
    cyc();
    rst_n = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    chk("rmh_go", {31'd0, bus.urx_go}, 32'd0);
    chk("rmh_count", {27'd0, bus.count}, 32'd0);
    cyc();
    chk("rmh_go_held", {31'd0, bus.urx_go}, 32'd0);
    chk("rmh_no_push", {27'd0, bus.count}, 32'd0);
    bus.urx_data_ready = 1'b0;
    cyc();
    chk("rmh_go_rise", {31'd0, bus.urx_go}, 32'd1);
    chk("rmh_valid", {31'd0, bus.rd_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
